// File: rtl/pixel_mem_arbiter.sv
// Single-port pixel RAM arbiter: scanout reads have priority during active video,
// while a one-entry host write buffer drains in blanking or by stealing a cycle once starved.
module pixel_mem_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 6,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic [ADDR_W-1:0] scan_addr,
  input  logic              host_valid,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pixel_out,
  output logic              pixel_hold,
  output logic [7:0]        steal_count
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, PEND, WRITE} state_t;

  state_t            state_q, state_d;
  logic              buf_full_q, buf_full_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              host_ready_q, host_ready_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              read_pend_q, read_pend_d;
  logic [DATA_W-1:0] pixel_q, pixel_d;
  logic              hold_q, hold_d;
  logic [7:0]        steal_q, steal_d;

  logic accept, grant_write, grant_read;

  assign accept      = host_valid && host_ready_q;
  // Gated by rst so the RAM port is quiet while reset is held, even during active video.
  assign grant_write = !rst && buf_full_q && (!active || (starve_q >= LIMIT));
  assign grant_read  = !rst && !grant_write && active;

  always_comb begin
    mem_en    = grant_write || grant_read;
    mem_we    = grant_write;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_write) begin
      mem_addr  = buf_addr_q;
      mem_wdata = buf_data_q;
    end else if (grant_read) begin
      mem_addr  = scan_addr;
    end
  end

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    buf_full_d  = buf_full_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    starve_d    = starve_q;
    pixel_d     = pixel_q;
    steal_d     = steal_q;
    read_pend_d = grant_read;
    hold_d      = grant_write && active;

    unique case (state_q)
      IDLE:    if (accept) state_d = PEND;
      PEND:    if (grant_write) state_d = WRITE;
      WRITE:   state_d = accept ? PEND : IDLE;
      default: state_d = IDLE;
    endcase

    // Accept and write never coincide: host_ready is low whenever the buffer is full.
    if (accept) begin
      buf_full_d = 1'b1;
      buf_addr_d = host_addr;
      buf_data_d = host_data;
    end else if (grant_write) begin
      buf_full_d = 1'b0;
    end
    host_ready_d = !buf_full_d;

    if (!buf_full_q || grant_write) starve_d = '0;
    else if (active && (starve_q < LIMIT)) starve_d = starve_q + 1'b1;

    if (read_pend_q) pixel_d = mem_rdata;
    if (grant_write && active && (steal_q != 8'hFF)) steal_d = steal_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      buf_full_q   <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
      host_ready_q <= 1'b1;
      starve_q     <= '0;
      read_pend_q  <= 1'b0;
      pixel_q      <= '0;
      hold_q       <= 1'b0;
      steal_q      <= '0;
    end else begin
      state_q      <= state_d;
      buf_full_q   <= buf_full_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      host_ready_q <= host_ready_d;
      starve_q     <= starve_d;
      read_pend_q  <= read_pend_d;
      pixel_q      <= pixel_d;
      hold_q       <= hold_d;
      steal_q      <= steal_d;
    end
  end

  assign host_ready  = host_ready_q;
  assign pixel_out   = pixel_q;
  assign pixel_hold  = hold_q;
  assign steal_count = steal_q;

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Bench for pixel_mem_arbiter: behavioural RAM, host-write scoreboard checked by a
// write monitor, and one task per scenario.
module tb_pixel_mem_arbiter;

  localparam int AW = 11;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          active = 1'b0;
  logic [AW-1:0] scan_addr = '0;
  logic          host_valid = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_data = '0;
  logic          host_ready;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] pixel_out;
  logic          pixel_hold;
  logic [7:0]    steal_count;

  pixel_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .active(active), .scan_addr(scan_addr),
    .host_valid(host_valid), .host_addr(host_addr), .host_data(host_data),
    .host_ready(host_ready), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pixel_out(pixel_out), .pixel_hold(pixel_hold), .steal_count(steal_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_wr[$];
  logic [DW-1:0] exp_pix[$];
  logic [DW-1:0] ram [0:(1<<AW)-1];
  wr_t           mon_w;
  logic [DW-1:0] want_pix;
  int            total = 0;
  int            bad   = 0;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Every RAM write must match the oldest accepted host transfer.
  always @(negedge clk) begin
    if (!rst && mem_en && mem_we) begin
      total++;
      if (exp_wr.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        mon_w = exp_wr.pop_front();
        if ({mem_addr, mem_wdata} !== {mon_w.addr, mon_w.data}) begin
          bad++;
          $display("FAIL wr_data: got addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_wdata, mon_w.addr, mon_w.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_host(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_write);
    host_valid = 1'b1;
    host_addr  = a;
    host_data  = d;
    if (expect_write) exp_wr.push_back('{addr: a, data: d});
  endtask

  task automatic test_reset();
    rst = 1'b1; active = 1'b1; scan_addr = 11'h005;
    drive_host(11'h0AA, 6'h01, 1'b0);
    @(negedge clk);
    total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b, required 1", host_ready); end
    total++; if ({mem_en, mem_we} !== 2'b00) begin bad++; $display("FAIL rst_mem: got en/we=%b, required 00", {mem_en, mem_we}); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL rst_addr: got %h, required 0", mem_addr); end
    total++; if ({pixel_out, pixel_hold, steal_count} !== '0) begin
      bad++; $display("FAIL rst_outs: got pix=%h hold=%b steal=%0d, required 0", pixel_out, pixel_hold, steal_count);
    end
    host_valid = 1'b0; active = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_blanking_write();
    active = 1'b0;
    drive_host(11'h123, 6'h2A, 1'b1);
    @(negedge clk);
    total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL blank_ready0: got %b, required 1", host_ready); end
    tick();
    host_valid = 1'b0;
    @(negedge clk);
    total++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 11'h123, 6'h2A}) begin
      bad++; $display("FAIL blank_write: got en/we=%b addr=%h data=%h, required 11 123 2a",
                      {mem_en, mem_we}, mem_addr, mem_wdata);
    end
    total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL blank_busy: got %b, required 0", host_ready); end
    tick();
    @(negedge clk);
    total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL blank_ready1: got %b, required 1", host_ready); end
    total++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      bad++; $display("FAIL blank_idle: got en/we=%b addr=%h data=%h, required all 0",
                      {mem_en, mem_we}, mem_addr, mem_wdata);
    end
    total++; if (ram[11'h123] !== 6'h2A) begin bad++; $display("FAIL blank_ram: got %h, required 2a", ram[11'h123]); end
  endtask

  task automatic test_scanout();
    active = 1'b1; scan_addr = 11'h005;
    exp_pix.push_back(6'h15);
    @(negedge clk);
    total++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 11'h005}) begin
      bad++; $display("FAIL scan_read: got en/we=%b addr=%h, required 10 005", {mem_en, mem_we}, mem_addr);
    end
    tick();
    scan_addr = 11'h006;
    exp_pix.push_back(6'h0B);
    tick();
    @(negedge clk);
    want_pix = exp_pix.pop_front();
    total++; if (pixel_out !== want_pix) begin bad++; $display("FAIL scan_pix0: got %h, required %h", pixel_out, want_pix); end
    tick();
    @(negedge clk);
    want_pix = exp_pix.pop_front();
    total++; if (pixel_out !== want_pix) begin bad++; $display("FAIL scan_pix1: got %h, required %h", pixel_out, want_pix); end
    active = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    active = 1'b1; scan_addr = 11'h007;
    drive_host(11'h200, 6'h11, 1'b1);
    tick();
    host_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if ({mem_en, mem_we, pixel_hold} !== 3'b100) begin
        bad++; $display("FAIL starve_read%0d: got en/we/hold=%b, required 100", i, {mem_en, mem_we, pixel_hold});
      end
      tick();
    end
    @(negedge clk);
    total++; if ({mem_en, mem_we, mem_addr} !== {2'b11, 11'h200}) begin
      bad++; $display("FAIL starve_steal: got en/we=%b addr=%h, required 11 200", {mem_en, mem_we}, mem_addr);
    end
    tick();
    @(negedge clk);
    total++; if ({pixel_hold, steal_count} !== {1'b1, 8'd1}) begin
      bad++; $display("FAIL starve_hold: got hold=%b steal=%0d, required 1 1", pixel_hold, steal_count);
    end
    total++; if ({mem_en, mem_we} !== 2'b10) begin bad++; $display("FAIL starve_after: got en/we=%b, required 10", {mem_en, mem_we}); end
    tick();
    @(negedge clk);
    total++; if (pixel_hold !== 1'b0) begin bad++; $display("FAIL starve_pulse: got %b, required 0", pixel_hold); end
    active = 1'b0;
    tick();
  endtask

  task automatic test_back_pressure();
    active = 1'b1;
    drive_host(11'h300, 6'h01, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      host_addr = 11'h301 + 11'(i);
      host_data = 6'h02 + 6'(i);
      @(negedge clk);
      total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d: got %b, required 0", i, host_ready); end
      total++; if (mem_we !== (i == 4)) begin bad++; $display("FAIL bp_we%0d: got %b, required %b", i, mem_we, (i == 4)); end
      if (i == 4) host_valid = 1'b0;
      tick();
    end
    @(negedge clk);
    total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got %b, required 1", host_ready); end
    total++; if (steal_count !== 8'd2) begin bad++; $display("FAIL bp_steal: got %0d, required 2", steal_count); end
    total++; if (ram[11'h301] !== 6'h00) begin bad++; $display("FAIL bp_overwrite: got %h, required 00", ram[11'h301]); end
    active = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_pend();
    active = 1'b1;
    drive_host(11'h3F0, 6'h3F, 1'b0);
    tick();
    host_valid = 1'b0;
    @(negedge clk);
    total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL mid_pend: got %b, required 0", host_ready); end
    #1 rst = 1'b1;
    #1;
    total++; if ({host_ready, mem_en, mem_we, pixel_hold, steal_count, pixel_out} !== {1'b1, 3'b000, 8'd0, 6'd0}) begin
      bad++; $display("FAIL mid_rst: got ready=%b en/we=%b hold=%b steal=%0d pix=%h, required 1 00 0 0 0",
                      host_ready, {mem_en, mem_we}, pixel_hold, steal_count, pixel_out);
    end
    active = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL mid_nowrite%0d: got %b, required 0", i, mem_we); end
      tick();
    end
    total++; if (ram[11'h3F0] !== 6'h00) begin bad++; $display("FAIL mid_ram: got %h, required 00", ram[11'h3F0]); end
  endtask

  task automatic do_steal(input int n);
    bit seen = 1'b0;
    drive_host(11'h400 + 11'(n % 256), 6'(n), 1'b1);
    tick();
    host_valid = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (mem_we) seen = 1'b1;
      tick();
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL steal_timeout%0d: got no write in 10 cycles, required one", n);
    end
  endtask

  task automatic test_saturation();
    int want;
    active = 1'b1; scan_addr = 11'h005;
    for (int n = 1; n <= 300; n++) begin
      do_steal(n);
      if (n == 100 || n == 254 || n == 255 || n == 300) begin
        want = (n > 255) ? 255 : n;
        total++; if (steal_count !== 8'(want)) begin bad++; $display("FAIL sat_%0d: got %0d, required %0d", n, steal_count, want); end
      end
    end
    repeat (5) tick();
    total++; if (steal_count !== 8'd255) begin bad++; $display("FAIL sat_hold: got %0d, required 255", steal_count); end
    active = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    ram[5] = 6'h15;
    ram[6] = 6'h0B;
    ram[7] = 6'h33;
    test_reset();
    test_blanking_write();
    test_scanout();
    test_starvation();
    test_back_pressure();
    test_reset_mid_pend();
    test_saturation();
    total++; if (exp_wr.size() != 0) begin bad++; $display("FAIL wr_drain: got %0d pending, required 0", exp_wr.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
